code_mem_loadable: RTL



---
 rtl/code_mem_loadable.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/code_mem_loadable.sv
// Writable program memory for the MCU core: clears to NOP after reset, is filled
// by a byte-stream boot loader, and is read through a negedge-registered chip-select port.
module code_mem_loadable #(
    parameter int unsigned ADDRWIDTH    = 8,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 CS,
    input  logic [ADDRWIDTH-1:0] addr,
    output wire  [7:0]           dout,
    output logic                 mem_ready,
    input  logic                 boot_req,
    input  logic                 ld_valid,
    input  logic [7:0]           ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic [ADDRWIDTH:0]   load_len,
    output logic                 ovf
);

    localparam int unsigned DEPTH = 2 ** ADDRWIDTH;
    localparam int unsigned LW    = ADDRWIDTH + 1;

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam state_t RST_STATE = CLR_ON_RESET ? ST_CLR : ST_RUN;

    state_t               state, state_d;
    logic [ADDRWIDTH-1:0] ptr, ptr_d;
    logic                 pend, pend_d;
    logic [LW-1:0]        load_len_d;
    logic                 ovf_d;
    logic                 mem_ready_d, ld_ready_d;
    logic                 we;
    logic [7:0]           wdata;
    logic [7:0]           data;
    logic [7:0]           mem [DEPTH];

    logic ptr_last;
    logic beat;

    assign ptr_last = (ptr == ADDRWIDTH'(DEPTH - 1));
    assign beat     = ld_valid & ld_ready;

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            ptr       <= '0;
            pend      <= 1'b0;
            load_len  <= '0;
            ovf       <= 1'b0;
            mem_ready <= 1'b0;
            ld_ready  <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            pend      <= pend_d;
            load_len  <= load_len_d;
            ovf       <= ovf_d;
            mem_ready <= mem_ready_d;
            ld_ready  <= ld_ready_d;
        end
    end

    // Next-state, pointer and array write control
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        pend_d     = pend;
        load_len_d = load_len;
        ovf_d      = ovf;
        we         = 1'b0;
        wdata      = 8'h00;

        unique case (state)
            ST_CLR: begin
                we    = 1'b1;
                ptr_d = ptr + ADDRWIDTH'(1);
                if (boot_req) pend_d = 1'b1;
                if (ptr_last) begin
                    ptr_d  = '0;
                    pend_d = 1'b0;
                    if (pend || boot_req) begin
                        state_d    = ST_LOAD;
                        load_len_d = '0;
                        ovf_d      = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (boot_req) begin
                    state_d    = ST_LOAD;
                    ptr_d      = '0;
                    load_len_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    we         = 1'b1;
                    wdata      = ld_data;
                    ptr_d      = ptr + ADDRWIDTH'(1);
                    load_len_d = load_len + LW'(1);
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end else if (ptr_last) begin
                        // Image longer than the array: keep what fits and stop
                        state_d = ST_RUN;
                        ovf_d   = 1'b1;
                    end
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Handshake outputs follow the state being entered
    always_comb begin
        mem_ready_d = 1'b0;
        ld_ready_d  = 1'b0;
        unique case (state_d)
            ST_RUN:  mem_ready_d = 1'b1;
            ST_LOAD: ld_ready_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[ptr] <= wdata;
    end

    // Fetch read register on the falling edge; NOP outside RUN
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= 8'h00;
        end else if (state == ST_RUN) begin
            data <= mem[addr];
        end else begin
            data <= 8'h00;
        end
    end

    assign dout = CS ? 8'hzz : data;

endmodule
